// File: rtl/viterbi_pkg.sv
// Shared trellis definitions for the rate-1/2, K=3 convolutional code (G0=7, G1=5).
// The encoder and the Viterbi decoder both use this state numbering.
package viterbi_pkg;

    localparam int K          = 3;
    localparam int NUM_STATES = 4;
    localparam logic [2:0] G0 = 3'b111;
    localparam logic [2:0] G1 = 3'b101;

    typedef enum logic [1:0] {
        DATA,
        TAIL1,
        TAIL2,
        DRAIN
    } enc_state_e;

    // s[1] is the newest bit, so the new input shifts in from the top.
    function automatic logic [1:0] next_state(input logic [1:0] s, input logic u);
        return {u, s[1]};
    endfunction

    function automatic logic [1:0] branch_sym(input logic [1:0] s, input logic u);
        logic [2:0] taps;
        taps = {u, s};
        return {^(taps & G0), ^(taps & G1)};
    endfunction

endpackage

// File: rtl/conv_encoder_if.sv
// Input bit stream, output symbol stream and frame status of the convolutional encoder.
interface conv_encoder_if #(
    parameter int CNT_W = 16
);
    logic             in_valid_i;
    logic             in_bit_i;
    logic             in_last_i;
    logic             in_ready_o;
    logic             sym_valid_o;
    logic [1:0]       sym_o;
    logic             sym_last_o;
    logic             sym_ready_i;
    logic [CNT_W-1:0] frame_bits_o;
    logic             frame_done_o;

    modport master (
        output in_valid_i, in_bit_i, in_last_i, sym_ready_i,
        input  in_ready_o, sym_valid_o, sym_o, sym_last_o, frame_bits_o, frame_done_o
    );

    modport slave (
        input  in_valid_i, in_bit_i, in_last_i, sym_ready_i,
        output in_ready_o, sym_valid_o, sym_o, sym_last_o, frame_bits_o, frame_done_o
    );
endinterface

// File: rtl/conv_encoder.sv
// Rate-1/2 convolutional encoder with a single registered output symbol and
// automatic two-bit zero tail so every frame ends the trellis in state 0.
module conv_encoder #(
    parameter int K     = 3,
    parameter int CNT_W = 16
) (
    input logic           clk_i,
    input logic           rst_ni,
    conv_encoder_if.slave bus
);
    import viterbi_pkg::*;

    enc_state_e       state_q, state_d;
    logic [K-2:0]     trellis_q;
    logic             sym_valid_q;
    logic             sym_last_q;
    logic [1:0]       sym_q;
    logic [CNT_W-1:0] frame_bits_q;
    logic             new_frame_q;

    logic slot_free;
    logic load;
    logic load_u;
    logic load_last;
    logic data_accept;
    logic in_ready;
    logic frame_done;

    assign slot_free = !sym_valid_q || bus.sym_ready_i;

    // The output register is refilled in the same cycle it drains, so data
    // and tail symbols stream at one per cycle when the sink keeps up.
    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        load_u      = 1'b0;
        load_last   = 1'b0;
        data_accept = 1'b0;
        in_ready    = 1'b0;
        frame_done  = 1'b0;
        case (state_q)
            DATA: begin
                in_ready = slot_free;
                if (bus.in_valid_i && slot_free) begin
                    load        = 1'b1;
                    load_u      = bus.in_bit_i;
                    data_accept = 1'b1;
                    if (bus.in_last_i) begin
                        state_d = TAIL1;
                    end
                end
            end
            TAIL1: begin
                if (slot_free) begin
                    load    = 1'b1;
                    state_d = TAIL2;
                end
            end
            TAIL2: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_last = 1'b1;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (sym_valid_q && bus.sym_ready_i && sym_last_q) begin
                    frame_done = 1'b1;
                    state_d    = DATA;
                end
            end
            default: state_d = DATA;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DATA;
        end else begin
            state_q <= state_d;
        end
    end

    // Trellis state and symbol register advance together; an unreloaded
    // symbol keeps its value but loses valid/last once consumed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trellis_q   <= '0;
            sym_q       <= 2'b00;
            sym_valid_q <= 1'b0;
            sym_last_q  <= 1'b0;
        end else if (load) begin
            trellis_q   <= next_state(trellis_q, load_u);
            sym_q       <= branch_sym(trellis_q, load_u);
            sym_valid_q <= 1'b1;
            sym_last_q  <= load_last;
        end else if (bus.sym_ready_i) begin
            sym_valid_q <= 1'b0;
            sym_last_q  <= 1'b0;
        end
    end

    // The count restarts at 1 on the first bit of each frame and otherwise
    // holds, so the previous frame's length stays visible between frames.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_bits_q <= '0;
            new_frame_q  <= 1'b1;
        end else begin
            if (data_accept) begin
                new_frame_q <= 1'b0;
                if (new_frame_q) begin
                    frame_bits_q <= CNT_W'(1);
                end else if (frame_bits_q != {CNT_W{1'b1}}) begin
                    frame_bits_q <= frame_bits_q + CNT_W'(1);
                end
            end
            if (frame_done) begin
                new_frame_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready_o   = in_ready;
    assign bus.sym_valid_o  = sym_valid_q;
    assign bus.sym_o        = sym_q;
    assign bus.sym_last_o   = sym_last_q;
    assign bus.frame_bits_o = frame_bits_q;
    assign bus.frame_done_o = frame_done;

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: a sliding-window reference model checked
// every cycle, plus literal symbol sequences for the hand-computed frames.
module tb_conv_encoder;

    localparam int CNT_W    = 6;
    localparam int MAX_BITS = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;

    conv_encoder_if #(.CNT_W(CNT_W)) bus ();

    conv_encoder #(.K(3), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [2:0] exp_q[$];
    logic [2:0] log_q[$];
    logic [2:0] lit_q[$];
    logic       tx_q[$];
    int         hist[$];
    int         model_bits;
    bit         model_new_frame;
    int         done_cnt;
    int         stall_cnt;
    int         sink_mode;
    int         sink_idx;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Symbol = XOR of the input bit with the bits one and two places earlier in the frame.
    task automatic model_push(input int u, input logic last);
        int n;
        int b1;
        int b2;
        hist.push_back(u);
        n  = hist.size();
        b1 = (n >= 2) ? hist[n-2] : 0;
        b2 = (n >= 3) ? hist[n-3] : 0;
        exp_q.push_back({last, 1'(u ^ b1 ^ b2), 1'(u ^ b2)});
    endtask

    always @(negedge clk) begin
        logic [2:0] front;
        logic       has_last;
        logic       exp_ready;
        if (!rst_n) begin
            check_output("rst_sym_valid", 32'(bus.sym_valid_o), 0);
            check_output("rst_sym", 32'(bus.sym_o), 0);
            check_output("rst_sym_last", 32'(bus.sym_last_o), 0);
            check_output("rst_frame_done", 32'(bus.frame_done_o), 0);
            check_output("rst_frame_bits", 32'(bus.frame_bits_o), 0);
            check_output("rst_in_ready", 32'(bus.in_ready_o), 1);
            exp_q.delete();
            hist.delete();
            model_bits      = 0;
            model_new_frame = 1'b1;
        end else begin
            has_last = 1'b0;
            foreach (exp_q[i]) if (exp_q[i][2]) has_last = 1'b1;
            exp_ready = !has_last && (exp_q.size() == 0 || bus.sym_ready_i);
            check_output("sym_valid", 32'(bus.sym_valid_o), 32'(exp_q.size() != 0));
            check_output("in_ready", 32'(bus.in_ready_o), 32'(exp_ready));
            check_output("frame_bits", 32'(bus.frame_bits_o), 32'(model_bits));
            if (bus.frame_done_o) done_cnt++;
            if (exp_q.size() != 0) begin
                front = exp_q[0];
                check_output("sym", 32'(bus.sym_o), 32'(front[1:0]));
                check_output("sym_last", 32'(bus.sym_last_o), 32'(front[2]));
                check_output("frame_done", 32'(bus.frame_done_o), 32'(front[2] && bus.sym_ready_i));
                if (bus.sym_ready_i) begin
                    log_q.push_back({bus.sym_last_o, bus.sym_o});
                    void'(exp_q.pop_front());
                    if (front[2]) model_new_frame = 1'b1;
                end
            end else begin
                check_output("frame_done_idle", 32'(bus.frame_done_o), 0);
            end
            if (bus.in_valid_i && !bus.in_ready_o) stall_cnt++;
            if (bus.in_valid_i && bus.in_ready_o) begin
                if (model_new_frame) model_bits = 1;
                else if (model_bits < MAX_BITS) model_bits++;
                model_new_frame = 1'b0;
                model_push(int'(bus.in_bit_i), 1'b0);
                if (bus.in_last_i) begin
                    model_push(0, 1'b0);
                    model_push(0, 1'b1);
                    hist.delete();
                end
            end
        end
    end

    initial begin
        bus.sym_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (sink_mode)
                0: bus.sym_ready_i = 1'b1;
                1: begin
                    case (sink_idx % 4)
                        0, 3:    bus.sym_ready_i = 1'b1;
                        default: bus.sym_ready_i = 1'b0;
                    endcase
                    sink_idx++;
                end
                default: bus.sym_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic set_idle();
        bus.in_valid_i = 1'b0;
        bus.in_bit_i   = 1'b0;
        bus.in_last_i  = 1'b0;
    endtask

    // Sends tx_q; returns at posedge+1 right after the final bit is accepted.
    task automatic apply_stimulus(input bit gaps, input bit with_last);
        int   budget;
        logic acc;
        for (int i = 0; i < tx_q.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.in_valid_i = 1'b0;
                    bus.in_bit_i   = 1'($urandom_range(0, 1));
                    bus.in_last_i  = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
            bus.in_valid_i = 1'b1;
            bus.in_bit_i   = tx_q[i];
            bus.in_last_i  = with_last && (i == tx_q.size() - 1);
            budget = 0;
            forever begin
                @(negedge clk);
                acc = bus.in_valid_i && bus.in_ready_o;
                @(posedge clk);
                #1;
                if (acc) break;
                budget++;
                if (budget > 100) begin
                    check_output("accept_timeout", 0, 1);
                    break;
                end
            end
        end
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            #1;
            budget++;
            if (budget > 500) begin
                check_output("drain_timeout", 32'(exp_q.size()), 0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string name);
        check_output({name, "_len"}, 32'(log_q.size()), 32'(lit_q.size()));
        for (int i = 0; i < lit_q.size() && i < log_q.size(); i++) begin
            check_output($sformatf("%s_sym%0d", name, i), 32'(log_q[i]), 32'(lit_q[i]));
        end
    endtask

    task automatic start_test(input int mode);
        sink_mode = mode;
        sink_idx  = 0;
        log_q.delete();
        done_cnt  = 0;
        stall_cnt = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        sink_mode = 0;
        sink_idx  = 0;
        #2;
        check_output("init_in_ready", 32'(bus.in_ready_o), 1);
        check_output("init_sym_valid", 32'(bus.sym_valid_o), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        start_test(0);
        tx_q = '{1'b1, 1'b0, 1'b1, 1'b1};
        apply_stimulus(0, 1);
        set_idle();
        wait_idle();
        lit_q = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
        check_log("frame1011");
        check_output("frame1011_bits", 32'(bus.frame_bits_o), 4);
        check_output("frame1011_done", 32'(done_cnt), 1);

        start_test(0);
        tx_q = '{1'b1};
        apply_stimulus(0, 1);
        apply_stimulus(0, 1);
        set_idle();
        wait_idle();
        lit_q = '{3'b011, 3'b010, 3'b111, 3'b011, 3'b010, 3'b111};
        check_log("onebit");
        check_output("onebit_bits", 32'(bus.frame_bits_o), 1);
        check_output("onebit_done", 32'(done_cnt), 2);

        start_test(1);
        tx_q = '{1'b1, 1'b0, 1'b1, 1'b1};
        apply_stimulus(0, 1);
        set_idle();
        wait_idle();
        lit_q = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
        check_log("stall1011");

        start_test(0);
        tx_q = '{1'b1, 1'b1};
        apply_stimulus(0, 1);
        tx_q = '{1'b0, 1'b1};
        apply_stimulus(0, 1);
        set_idle();
        wait_idle();
        lit_q = '{3'b011, 3'b001, 3'b001, 3'b111, 3'b000, 3'b011, 3'b010, 3'b111};
        check_log("b2b");
        check_output("b2b_gap", 32'(stall_cnt), 3);
        check_output("b2b_done", 32'(done_cnt), 2);

        start_test(0);
        tx_q = '{1'b1, 1'b0};
        apply_stimulus(0, 0);
        set_idle();
        #3;
        rst_n = 1'b0;
        #1;
        check_output("midrst_sym_valid", 32'(bus.sym_valid_o), 0);
        check_output("midrst_sym", 32'(bus.sym_o), 0);
        check_output("midrst_frame_bits", 32'(bus.frame_bits_o), 0);
        check_output("midrst_in_ready", 32'(bus.in_ready_o), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        log_q.delete();
        tx_q = '{1'b1};
        apply_stimulus(0, 1);
        set_idle();
        wait_idle();
        lit_q = '{3'b011, 3'b010, 3'b111};
        check_log("after_rst");

        start_test(2);
        for (int f = 0; f < 20; f++) begin
            tx_q.delete();
            repeat ($urandom_range(1, 8)) tx_q.push_back(1'($urandom_range(0, 1)));
            apply_stimulus(1, 1);
            if ($urandom_range(0, 1) == 1) set_idle();
        end
        set_idle();
        wait_idle();
        check_output("random_done", 32'(done_cnt), 20);

        start_test(0);
        tx_q.delete();
        repeat ((1 << CNT_W) + 3) tx_q.push_back(1'($urandom_range(0, 1)));
        apply_stimulus(0, 1);
        set_idle();
        wait_idle();
        check_output("sat_bits", 32'(bus.frame_bits_o), MAX_BITS);
        check_output("sat_done", 32'(done_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
